// File: rtl/instruction_prefetch_if.sv
// Memory-side and fetch-side signals of the instruction prefetch unit.
// master = prefetch unit, slave = surrounding memory/fetch environment.
interface instruction_prefetch_if;
    logic        write_pc_i;
    logic [31:0] pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    modport master (
        input  write_pc_i, pc_i, mem_ack_i, mem_data_i, instr_ready_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o
    );

    modport slave (
        output write_pc_i, pc_i, mem_ack_i, mem_data_i, instr_ready_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o
    );
endinterface

// File: rtl/instruction_prefetch.sv
// Fetch PC plus DEPTH-entry {pc,instr} FIFO; ack-to-valid 1 cycle, mem_req_o drops while full.
// Define INSTRUCTION_PREFETCH_BYPASS_EN to present an acked word directly when the FIFO is empty.
module instruction_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    instruction_prefetch_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_fetch_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic [31:0]       r_fifo_instr [DEPTH];

    logic              w_run;
    logic              w_req;
    logic              w_nonempty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [31:0]       w_instr;
    logic [31:0]       w_pc;
    logic              w_unused;

    // Request issue starts one cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN:  w_run       = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_nonempty = (r_count != '0);
    assign w_req      = w_run && (r_count != FULL_CNT);
    assign w_accept   = w_req && bus.mem_ack_i && !bus.write_pc_i;
    assign w_pop      = w_nonempty && bus.instr_ready_i && !bus.write_pc_i;

`ifdef INSTRUCTION_PREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass = w_accept && !w_nonempty;
    // A bypassed word taken by the consumer never enters storage.
    assign w_push   = w_accept && !(w_bypass && bus.instr_ready_i);
`else
    assign w_push   = w_accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (bus.write_pc_i) begin
            r_fetch_pc <= {bus.pc_i[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
            r_fifo_instr[r_wr_ptr] <= bus.mem_data_i;
        end
    end

    always_comb begin
        w_valid = w_nonempty;
        w_instr = w_nonempty ? r_fifo_instr[r_rd_ptr] : 32'd0;
        w_pc    = w_nonempty ? r_fifo_pc[r_rd_ptr]    : 32'd0;
`ifdef INSTRUCTION_PREFETCH_BYPASS_EN
        if (w_bypass) begin
            w_valid = 1'b1;
            w_instr = bus.mem_data_i;
            w_pc    = r_fetch_pc;
        end
`endif
    end

    assign bus.mem_req_o     = w_req;
    assign bus.mem_addr_o    = r_fetch_pc;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_instr;
    assign bus.pc_o          = w_pc;

    assign w_unused = &{1'b0, bus.pc_i[1:0]};
endmodule

// File: tb/tb_instruction_prefetch.sv
// Self-checking bench for instruction_prefetch: queue-based reference model compared every sampled cycle.
module tb_instruction_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef INSTRUCTION_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instruction_prefetch_if bus();

    instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    logic [63:0] sb[$];
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic drive(input bit ack, input logic [31:0] data, input bit rdy,
                         input bit wpc, input logic [31:0] pcin);
        @(negedge clk);
        bus.mem_ack_i     = ack;
        bus.mem_data_i    = data;
        bus.instr_ready_i = rdy;
        bus.write_pc_i    = wpc;
        bus.pc_i          = pcin;
        #2;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RESET_PC;
        sb.delete();
    endtask

    // Expected outputs for the current inputs, then advance to the next clock edge.
    task automatic model_step();
        logic        acc;
        logic [63:0] h;
        e_req  = m_run && (sb.size() != DEPTH);
        e_addr = m_pc;
        acc    = e_req && bus.mem_ack_i && !bus.write_pc_i;
        if (BYP && acc) sb.push_back({m_pc, bus.mem_data_i});
        e_valid = (sb.size() != 0);
        h       = e_valid ? sb[0] : 64'd0;
        e_pc    = h[63:32];
        e_instr = h[31:0];
        if (!BYP && acc) sb.push_back({m_pc, bus.mem_data_i});
        if (e_valid && bus.instr_ready_i && !bus.write_pc_i) void'(sb.pop_front());
        if (bus.write_pc_i) begin
            sb.delete();
            m_pc = {bus.pc_i[31:2], 2'b00};
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        m_run = 1'b1;
    endtask

    function automatic logic [97:0] obs();
        return {bus.mem_req_o, bus.mem_addr_o, bus.instr_valid_o, bus.pc_o, bus.instr_o};
    endfunction

    function automatic logic [97:0] expv();
        return {e_req, e_addr, e_valid, e_pc, e_instr};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 32'd0, 0, 0, 32'd0);
        n_checks++;
        if (obs() !== {1'b0, RESET_PC, 1'b0, 32'd0, 32'd0})
            $display("FAIL reset_outputs got=%h exp=%h", obs(), {1'b0, RESET_PC, 1'b0, 32'd0, 32'd0});
        else n_pass++;
        model_reset();
        drive(0, 32'd0, 0, 0, 32'd0);
        rst = 1'b1;
        #1;
        model_step();
        n_checks++;
        if (bus.mem_req_o !== 1'b0) $display("FAIL reset_first_cycle_req got=%b exp=0", bus.mem_req_o);
        else n_pass++;
        drive(0, 32'd0, 0, 0, 32'd0);
        model_step();
        n_checks++;
        if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, RESET_PC})
            $display("FAIL reset_first_req got=%b/%h exp=1/%h", bus.mem_req_o, bus.mem_addr_o, RESET_PC);
        else n_pass++;
    endtask

    task automatic test_stream();
        int nval = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1, m_pc + 32'h100, 1, 0, 32'd0);
            model_step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL stream k=%0d got=%h exp=%h", k, obs(), expv());
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (bus.instr_valid_o !== BYP)
                    $display("FAIL stream_first_valid got=%b exp=%b", bus.instr_valid_o, BYP);
                else n_pass++;
            end
            if (bus.instr_valid_o === 1'b1) nval++;
        end
        n_checks++;
        if (nval != (BYP ? 12 : 11)) $display("FAIL stream_throughput got=%0d exp=%0d", nval, BYP ? 12 : 11);
        else n_pass++;
    endtask

    task automatic test_full();
        int nacc = 0;
        drive(0, 32'd0, 0, 1, 32'd0);
        model_step();
        for (int k = 0; k < 6; k++) begin
            drive(1, m_pc + 32'h100, 0, 0, 32'd0);
            model_step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL full_fill k=%0d got=%h exp=%h", k, obs(), expv());
            else n_pass++;
            if (bus.mem_req_o === 1'b1) nacc++;
        end
        n_checks++;
        if (nacc != DEPTH) $display("FAIL full_push_count got=%0d exp=%0d", nacc, DEPTH);
        else n_pass++;
        n_checks++;
        if ({bus.mem_req_o, bus.instr_valid_o, bus.pc_o} !== {1'b0, 1'b1, 32'd0})
            $display("FAIL full_state got=%b/%b/%h exp=0/1/00000000", bus.mem_req_o, bus.instr_valid_o, bus.pc_o);
        else n_pass++;
        drive(1, m_pc + 32'h100, 1, 0, 32'd0);
        model_step();
        n_checks++;
        if (bus.mem_req_o !== 1'b0) $display("FAIL full_pop_cycle_req got=%b exp=0", bus.mem_req_o);
        else n_pass++;
        drive(0, 32'd0, 0, 0, 32'd0);
        model_step();
        n_checks++;
        if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, 32'h10})
            $display("FAIL full_resume got=%b/%h exp=1/00000010", bus.mem_req_o, bus.mem_addr_o);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [31:0] first_pc = 32'hFFFF_FFFF;
        drive(0, 32'd0, 0, 1, 32'h1000);
        model_step();
        for (int k = 0; k < 3; k++) begin
            drive(1, m_pc + 32'h100, 0, 0, 32'd0);
            model_step();
        end
        drive(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_2003);
        model_step();
        n_checks++;
        if (obs() !== expv()) $display("FAIL redir_cycle got=%h exp=%h", obs(), expv());
        else n_pass++;
        drive(0, 32'd0, 0, 0, 32'd0);
        model_step();
        n_checks++;
        if ({bus.instr_valid_o, bus.mem_addr_o} !== {1'b0, 32'h2000})
            $display("FAIL redir_next got=%b/%h exp=0/00002000", bus.instr_valid_o, bus.mem_addr_o);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            drive(1, m_pc + 32'h100, 1, 0, 32'd0);
            model_step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL redir_run k=%0d got=%h exp=%h", k, obs(), expv());
            else n_pass++;
            if (bus.instr_valid_o === 1'b1 && first_pc == 32'hFFFF_FFFF) first_pc = bus.pc_o;
        end
        n_checks++;
        if (first_pc !== 32'h2000) $display("FAIL redir_first_pc got=%h exp=00002000", first_pc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] seen[3] = '{32'h1, 32'h1, 32'h1};
        int          n = 0;
        drive(0, 32'd0, 0, 1, 32'hFFFF_FFF8);
        model_step();
        for (int k = 0; k < 6; k++) begin
            drive(1, m_pc + 32'h100, 1, 0, 32'd0);
            model_step();
            if (bus.instr_valid_o === 1'b1 && n < 3) begin
                seen[n] = bus.pc_o;
                n++;
            end
        end
        n_checks++;
        if ({seen[0], seen[1], seen[2]} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_seq got=%h,%h,%h exp=fffffff8,fffffffc,00000000", seen[0], seen[1], seen[2]);
        else n_pass++;
    endtask

    task automatic test_random();
        int nerr = 0;
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 49) == 0, $urandom);
            model_step();
            n_checks++;
            if (obs() !== expv()) begin
                if (nerr < 10) $display("FAIL random k=%0d got=%h exp=%h", k, obs(), expv());
                nerr++;
            end else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        drive(0, 32'd0, 0, 1, 32'h40);
        model_step();
        for (int k = 0; k < 6; k++) begin
            drive(1, m_pc + 32'h100, 0, 0, 32'd0);
            model_step();
        end
        n_checks++;
        if ({bus.mem_req_o, bus.instr_valid_o, bus.pc_o} !== {1'b0, 1'b1, 32'h40})
            $display("FAIL arst_full got=%b/%b/%h exp=0/1/00000040", bus.mem_req_o, bus.instr_valid_o, bus.pc_o);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== {1'b0, RESET_PC, 1'b0, 32'd0, 32'd0})
            $display("FAIL arst_immediate got=%h exp=%h", obs(), {1'b0, RESET_PC, 1'b0, 32'd0, 32'd0});
        else n_pass++;
        model_reset();
        drive(0, 32'd0, 0, 0, 32'd0);
        drive(0, 32'd0, 0, 0, 32'd0);
        rst = 1'b1;
        #1;
        model_step();
        n_checks++;
        if (bus.mem_req_o !== 1'b0) $display("FAIL arst_release_req got=%b exp=0", bus.mem_req_o);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive(1, m_pc + 32'h100, 1, 0, 32'd0);
            model_step();
            n_checks++;
            if (obs() !== expv()) $display("FAIL arst_resume k=%0d got=%h exp=%h", k, obs(), expv());
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if ({bus.mem_req_o, bus.mem_addr_o} !== {1'b1, RESET_PC})
                    $display("FAIL arst_first_req got=%b/%h exp=1/%h", bus.mem_req_o, bus.mem_addr_o, RESET_PC);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.mem_ack_i     = 1'b0;
        bus.mem_data_i    = 32'd0;
        bus.instr_ready_i = 1'b0;
        bus.write_pc_i    = 1'b0;
        bus.pc_i          = 32'd0;
        model_reset();
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instruction_prefetch.md
# instruction_prefetch

Upstream neighbour of the instruction fetch stage. It owns the fetch program counter and issues word reads to instruction memory over a request/acknowledge handshake. Returned words are buffered, with their addresses, in a DEPTH-entry FIFO. The FIFO head is presented to the fetch stage under a valid/ready handshake, and a redirect (branch/exception) flushes all buffered and in-flight work.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- write_pc_i  input  1  redirect strobe
- pc_i  input  32  redirect target; bits [1:0] ignored, treated as 0
- mem_req_o  output  1  read request to instruction memory
- mem_addr_o  output  32  word address of request, equal to the fetch PC
- mem_ack_i  input  1  request accepted; mem_data_i valid this cycle
- mem_data_i  input  32  instruction word for mem_addr_o
- instr_valid_o  output  1  FIFO head valid
- instr_o  output  32  head instruction
- pc_o  output  32  head instruction address
- instr_ready_i  input  1  consumer takes head this cycle

## Operation
- State:
  - fetch_pc (32 bits)
  - FIFO storage of {pc, instr} × DEPTH
  - rd_ptr, wr_ptr (log2 DEPTH bits each, wrapping)
  - count (0..DEPTH)
  - run flag
- Reset (rst low, async):
  - fetch_pc=RESET_PC, count=0, pointers=0, run=0
  - Outputs: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0
- run sets on the first rising edge after rst releases and stays 1.
- mem_req_o = run & (count != DEPTH). mem_addr_o = fetch_pc.
- Memory may hold off with mem_ack_i=0 indefinitely. mem_addr_o may change while mem_req_o is high and unacked, but only on redirect.
- Accept: mem_req_o & mem_ack_i & !write_pc_i:
  - push {fetch_pc, mem_data_i}
  - fetch_pc += 4; 32-bit wrap, so 32'hFFFF_FFFC → 0
- Pop: instr_valid_o & instr_ready_i & !write_pc_i advances rd_ptr.
- A push and a pop in the same cycle leave count unchanged.
- instr_valid_o = (count != 0). instr_o and pc_o show the head entry when valid and are forced to 0 when empty.
- Redirect (write_pc_i=1):
  - count, rd_ptr and wr_ptr all go to 0
  - fetch_pc = {pc_i[31:2], 2'b00}
  - A coincident mem_ack_i word is discarded and a coincident pop is void.
  - Redirect takes priority over all other events.
- mem_ack_i while mem_req_o=0 is ignored.

## Timing
- Memory latency is 0: data arrives on the same cycle as the ack.
- Ack in cycle N gives instr_valid_o in cycle N+1 when the FIFO was empty (see Configuration).
- Sustained throughput is 1 instruction/cycle when mem_ack_i and instr_ready_i are both held high.
- Full (count=DEPTH): mem_req_o drops combinationally and rises again in the cycle after the first pop.
- Redirect in cycle N:
  - cycle N+1: mem_addr_o = new target, instr_valid_o=0
  - earliest redirected instruction valid in cycle N+2
- First request after reset: the cycle following the first rising edge after rst release.

## Configuration
- INSTRUCTION_PREFETCH_BYPASS_EN defined: zero-latency bypass.
  - Condition: count=0, mem_req_o & mem_ack_i, no write_pc_i.
  - In that cycle instr_valid_o=1, instr_o=mem_data_i, pc_o=fetch_pc.
  - If instr_ready_i=1 the word is consumed and not pushed; otherwise it is pushed as normal.
- Undefined: no bypass; outputs come only from FIFO storage, giving the one-cycle latency above.
- Tests marked [bypass] expect different timing per macro.

## Test plan
- Reset, then hold mem_ack_i=1 and instr_ready_i=1 with mem_data_i = address+32'h100:
  - requests at addresses 0,4,8,…
  - pc_o/instr_o sequence 0/0x100, 4/0x104, … on consecutive cycles, starting one cycle after the first ack (same cycle with bypass) [bypass].
- instr_ready_i=0 with DEPTH=4 and acks every cycle:
  - exactly 4 pushes (pc 0..0xC), then mem_req_o=0
  - one pop gives mem_req_o=1 next cycle at address 0x10
- FIFO holding 3 entries, then write_pc_i=1 with pc_i=32'h0000_2003 and a coincident ack:
  - next cycle instr_valid_o=0, mem_addr_o=0x2000
  - the ack data never appears on instr_o
- Random ack/ready stalls over 1000 cycles checked against a reference queue model: no loss, duplication or reordering; pc_o always matches its instruction.
- Redirect to 32'hFFFF_FFF8 with continuous acks: pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst low mid-stream with a full FIFO:
  - all outputs go to reset values immediately, without waiting for a clock edge
  - after release, mem_req_o=0 for one cycle, then requests resume at RESET_PC
